// File: rtl/pet_sram_pkg.sv
// rtl/pet_sram_pkg.sv - shared types for the PET SDRAM port arbiter
package pet_sram_pkg;

  localparam int AW_DEFAULT = 25;
  localparam int TIMER_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    G_DL   = 2'd0,
    G_TAPE = 2'd1,
    G_AUX  = 2'd2
  } grant_t;

endpackage

// File: rtl/pet_sram_rr_pick.sv
// rtl/pet_sram_rr_pick.sv - tape/aux round-robin picker with download override
module pet_sram_rr_pick
  import pet_sram_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   dl_req,
  input  logic   tape_req,
  input  logic   aux_req,
  input  logic   take,
  output logic   valid,
  output grant_t grant
);

  logic favour_aux;

  always_comb begin
    valid = dl_req | tape_req | aux_req;
    grant = G_DL;
    if (dl_req)
      grant = G_DL;
    else if (tape_req && aux_req)
      grant = favour_aux ? G_AUX : G_TAPE;
    else if (tape_req)
      grant = G_TAPE;
    else if (aux_req)
      grant = G_AUX;
  end

  // Download grants leave the tape/aux turn untouched.
  always_ff @(posedge clk) begin
    if (reset)
      favour_aux <= 1'b0;
    else if (take && valid && grant != G_DL)
      favour_aux <= (grant == G_TAPE);
  end

endmodule

// File: rtl/pet_sram_arbiter.sv
// rtl/pet_sram_arbiter.sv - sequences download, tape and loader accesses onto one SDRAM port
module pet_sram_arbiter
  import pet_sram_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_busy,
  output logic          dl_overflow,
  input  logic          tape_rd,
  input  logic [AW-1:0] tape_addr,
  output logic [7:0]    tape_data,
  output logic          tape_ack,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [7:0]    aux_din,
  output logic [7:0]    aux_dout,
  output logic          aux_ack,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic          mem_ready,
  output logic          timeout_err
);

  localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(TIMEOUT);

  state_t              state, state_nxt;
  grant_t              owner;
  logic                dir_we;
  logic [TIMER_W-1:0]  timer;
  logic [AW-1:0]       dl_addr_q;
  logic [7:0]          dl_data_q;
  logic                pick_valid;
  grant_t              pick_grant;
  logic                timeout_hit;
  logic                xfer_end;
  logic                dl_free;
  logic [7:0]          rd_val;

  pet_sram_rr_pick u_pick (
    .clk      (clk),
    .reset    (reset),
    .dl_req   (dl_busy),
    .tape_req (tape_rd),
    .aux_req  (aux_req),
    .take     (state == IDLE),
    .valid    (pick_valid),
    .grant    (pick_grant)
  );

  assign timeout_hit = (state == WAIT) && !mem_ready && (timer == TIMEOUT_V);
  assign xfer_end    = (state == WAIT) && (mem_ready || timeout_hit);
  assign dl_free     = (state == DONE) && (owner == G_DL);
  assign rd_val      = mem_ready ? mem_dout : 8'hFF;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (xfer_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_we   = (state == ISSUE) && dir_we;
    mem_rd   = (state == ISSUE) && !dir_we;
    tape_ack = (state == DONE) && (owner == G_TAPE);
    aux_ack  = (state == DONE) && (owner == G_AUX);
  end

  // Grant latch, timer and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= G_DL;
      dir_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= 8'h00;
      timer       <= '0;
      tape_data   <= 8'h00;
      aux_dout    <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_grant;
            case (pick_grant)
              G_DL: begin
                mem_addr <= dl_addr_q;
                mem_din  <= dl_data_q;
                dir_we   <= 1'b1;
              end
              G_TAPE: begin
                mem_addr <= tape_addr;
                mem_din  <= 8'h00;
                dir_we   <= 1'b0;
              end
              default: begin
                mem_addr <= aux_addr;
                mem_din  <= aux_din;
                dir_we   <= aux_we;
              end
            endcase
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          if (timeout_hit)
            timeout_err <= 1'b1;
          else if (!mem_ready)
            timer <= timer + 1'b1;
          if (xfer_end && !dir_we) begin
            if (owner == G_TAPE)
              tape_data <= rd_val;
            else if (owner == G_AUX)
              aux_dout <= rd_val;
          end
        end
        default: ;
      endcase
    end
  end

  // The buffer frees in DONE, so a byte arriving that same cycle refills it cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_busy     <= 1'b0;
      dl_overflow <= 1'b0;
      dl_addr_q   <= '0;
      dl_data_q   <= 8'h00;
    end else if (dl_wr) begin
      if (!dl_busy || dl_free) begin
        dl_busy   <= 1'b1;
        dl_addr_q <= dl_addr;
        dl_data_q <= dl_data;
      end else begin
        dl_overflow <= 1'b1;
      end
    end else if (dl_free) begin
      dl_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pet_sram_arbiter.sv
// tb/tb_pet_sram_arbiter.sv - directed bench for pet_sram_arbiter
module tb_pet_sram_arbiter;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          dl_busy;
  logic          dl_overflow;
  logic          tape_rd;
  logic [AW-1:0] tape_addr;
  logic [7:0]    tape_data;
  logic          tape_ack;
  logic          aux_req;
  logic          aux_we;
  logic [AW-1:0] aux_addr;
  logic [7:0]    aux_din;
  logic [7:0]    aux_dout;
  logic          aux_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout = 8'h00;
  logic          mem_we;
  logic          mem_rd;
  logic          mem_ready = 1'b0;
  logic          timeout_err;

  always #5 clk = ~clk;

  pet_sram_arbiter #(.AW(AW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_busy(dl_busy), .dl_overflow(dl_overflow),
    .tape_rd(tape_rd), .tape_addr(tape_addr), .tape_data(tape_data), .tape_ack(tape_ack),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_din(aux_din),
    .aux_dout(aux_dout), .aux_ack(aux_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mem_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]    mem_arr [0:1023];
  logic          pend = 1'b0;
  int            cnt = 0;
  logic [AW-1:0] p_addr = '0;
  logic          p_we = 1'b0;

  int            st_cyc[$];
  logic          st_we[$];
  logic [AW-1:0] st_addr[$];
  logic [7:0]    st_din[$];
  int            ack_kind[$];
  logic [7:0]    ack_data[$];
  int            ack_cyc[$];

  // Memory responder and transfer log: ready arrives mem_lat cycles after a strobe (0 = never).
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        mem_ready = 1'b1;
        pend = 1'b0;
        if (!p_we) mem_dout = mem_arr[p_addr[9:0]];
      end
    end
    if (mem_we || mem_rd) begin
      st_cyc.push_back(cyc);
      st_we.push_back(mem_we);
      st_addr.push_back(mem_addr);
      st_din.push_back(mem_din);
      if (mem_lat > 0) begin
        pend = 1'b1;
        cnt = mem_lat;
        p_addr = mem_addr;
        p_we = mem_we;
      end
    end
    if (tape_ack) begin
      ack_kind.push_back(1); ack_data.push_back(tape_data); ack_cyc.push_back(cyc);
    end
    if (aux_ack) begin
      ack_kind.push_back(2); ack_data.push_back(aux_dout); ack_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    st_cyc.delete(); st_we.delete(); st_addr.delete(); st_din.delete();
    ack_kind.delete(); ack_data.delete(); ack_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dl_wr = 1'b0; tape_rd = 1'b0; aux_req = 1'b0; aux_we = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_tests++;
    if ({dl_busy, dl_overflow, tape_ack, aux_ack, mem_we, mem_rd, timeout_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000000",
        {dl_busy, dl_overflow, tape_ack, aux_ack, mem_we, mem_rd, timeout_err});
    end
    n_tests++;
    if ({mem_addr, mem_din, tape_data, aux_dout} !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr %0h din %0h tape %0h aux %0h expected all 0",
        mem_addr, mem_din, tape_data, aux_dout);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if ({mem_we, mem_rd, dl_busy} !== 3'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 000", {mem_we, mem_rd, dl_busy});
    end
  endtask

  task automatic test_single_download();
    int e0, clr;
    do_reset();
    mem_lat = 4;
    clear_logs();
    dl_addr = 25'h10; dl_data = 8'hA5; dl_wr = 1'b1; e0 = cyc;
    tick();
    dl_wr = 1'b0;
    n_tests++;
    if (dl_busy !== 1'b1) begin
      n_fail++; $display("FAIL dl_busy_set: got %b expected 1", dl_busy);
    end
    clr = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (dl_busy === 1'b0) begin clr = cyc; break; end
    end
    n_tests++;
    if (st_cyc.size() != 1) begin
      n_fail++; $display("FAIL dl_strobe_count: got %0d expected 1", st_cyc.size());
    end
    n_tests++;
    if (st_we[0] !== 1'b1 || st_addr[0] !== 25'h10 || st_din[0] !== 8'hA5) begin
      n_fail++; $display("FAIL dl_write: got we %b addr %0h din %0h expected we 1 addr 10 din a5",
        st_we[0], st_addr[0], st_din[0]);
    end
    n_tests++;
    if (st_cyc[0] != e0 + 2) begin
      n_fail++; $display("FAIL dl_strobe_latency: got cycle %0d expected %0d", st_cyc[0], e0 + 2);
    end
    n_tests++;
    if (clr != e0 + 8) begin
      n_fail++; $display("FAIL dl_busy_clear: got cycle %0d expected %0d", clr, e0 + 8);
    end
    n_tests++;
    if (dl_overflow !== 1'b0) begin
      n_fail++; $display("FAIL dl_no_overflow: got %b expected 0", dl_overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    mem_lat = 6;
    clear_logs();
    dl_addr = 25'h20; dl_data = 8'h5A; dl_wr = 1'b1;
    tick();
    dl_addr = 25'h21; dl_data = 8'h66;
    tick();
    dl_wr = 1'b0;
    n_tests++;
    if (dl_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b expected 1", dl_overflow);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dl_busy === 1'b0) break;
    end
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (st_cyc.size() != 1 || st_addr[0] !== 25'h20 || st_din[0] !== 8'h5A) begin
      n_fail++; $display("FAIL ovf_first_only: got %0d strobes addr %0h din %0h expected 1 addr 20 din 5a",
        st_cyc.size(), st_addr[0], st_din[0]);
    end
    n_tests++;
    if (dl_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b expected 1", dl_overflow);
    end
  endtask

  task automatic test_dl_in_done();
    int e0;
    do_reset();
    mem_lat = 2;
    clear_logs();
    dl_addr = 25'h30; dl_data = 8'h31; dl_wr = 1'b1; e0 = cyc;
    tick();
    dl_wr = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    dl_addr = 25'h31; dl_data = 8'h32; dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
    n_tests++;
    if (dl_busy !== 1'b1 || dl_overflow !== 1'b0) begin
      n_fail++; $display("FAIL done_refill: got busy %b ovf %b expected busy 1 ovf 0", dl_busy, dl_overflow);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dl_busy === 1'b0) break;
    end
    n_tests++;
    if (st_cyc.size() != 2 || st_addr[1] !== 25'h31 || st_din[1] !== 8'h32 || st_cyc[1] != e0 + 7) begin
      n_fail++; $display("FAIL done_second_write: got %0d strobes addr %0h din %0h cycle %0d expected 2 31 32 %0d",
        st_cyc.size(), st_addr[1], st_din[1], st_cyc[1], e0 + 7);
    end
  endtask

  task automatic test_round_robin();
    int acks;
    do_reset();
    mem_lat = 2;
    clear_logs();
    tape_addr = 25'h100; tape_rd = 1'b1;
    aux_addr = 25'h200; aux_we = 1'b0; aux_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tape_ack === 1'b1 || aux_ack === 1'b1) acks++;
      if (acks == 4) break;
    end
    tape_rd = 1'b0; aux_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_tests++;
    if (ack_kind.size() != 4 || st_cyc.size() != 4) begin
      n_fail++; $display("FAIL rr_counts: got %0d acks %0d strobes expected 4 4", ack_kind.size(), st_cyc.size());
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (ack_kind[k] != ((k % 2 == 0) ? 1 : 2) ||
          ack_data[k] !== ((k % 2 == 0) ? 8'h11 : 8'h22) ||
          st_addr[k] !== ((k % 2 == 0) ? 25'h100 : 25'h200) || st_we[k] !== 1'b0) begin
        n_fail++; $display("FAIL rr_order_%0d: got kind %0d data %0h addr %0h we %b", k,
          ack_kind[k], ack_data[k], st_addr[k], st_we[k]);
      end
    end
    n_tests++;
    if (tape_data !== 8'h11 || aux_dout !== 8'h22) begin
      n_fail++; $display("FAIL rr_hold: got tape %0h aux %0h expected 11 22", tape_data, aux_dout);
    end
  endtask

  task automatic test_priority();
    logic got;
    do_reset();
    mem_lat = 5;
    clear_logs();
    aux_addr = 25'h300; aux_we = 1'b0; aux_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_rd === 1'b1) break;
    end
    tick();
    dl_addr = 25'h40; dl_data = 8'h77; dl_wr = 1'b1;
    tape_addr = 25'h100; tape_rd = 1'b1;
    tick();
    dl_wr = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (aux_ack === 1'b1) aux_req = 1'b0;
      if (tape_ack === 1'b1) begin tape_rd = 1'b0; got = 1'b1; break; end
    end
    tick();
    n_tests++;
    if (got !== 1'b1) begin
      n_fail++; $display("FAIL prio_tape_done: got %b expected 1", got);
    end
    n_tests++;
    if (st_cyc.size() != 3 || st_addr[0] !== 25'h300 || st_addr[1] !== 25'h40 || st_addr[2] !== 25'h100) begin
      n_fail++; $display("FAIL prio_order: got %0d strobes %0h %0h %0h expected 3 300 40 100",
        st_cyc.size(), st_addr[0], st_addr[1], st_addr[2]);
    end
    n_tests++;
    if ({st_we[0], st_we[1], st_we[2]} !== 3'b010 || st_din[1] !== 8'h77) begin
      n_fail++; $display("FAIL prio_dirs: got we %b%b%b din %0h expected 010 77",
        st_we[0], st_we[1], st_we[2], st_din[1]);
    end
    n_tests++;
    if (ack_kind.size() != 2 || ack_kind[0] != 2 || ack_kind[1] != 1 || ack_data[0] !== 8'h33) begin
      n_fail++; $display("FAIL prio_acks: got %0d acks kinds %0d %0d data %0h expected 2 acks 2 1 data 33",
        ack_kind.size(), ack_kind[0], ack_kind[1], ack_data[0]);
    end
  endtask

  task automatic test_timeout();
    logic got;
    do_reset();
    mem_lat = 0;
    clear_logs();
    tape_addr = 25'h123; tape_rd = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tape_ack === 1'b1) begin tape_rd = 1'b0; got = 1'b1; break; end
    end
    tick();
    tick();
    n_tests++;
    if (got !== 1'b1 || ack_kind.size() != 1) begin
      n_fail++; $display("FAIL to_ack: got ack %b count %0d expected 1 1", got, ack_kind.size());
    end
    n_tests++;
    if (ack_cyc[0] - st_cyc[0] != 10) begin
      n_fail++; $display("FAIL to_latency: got %0d expected 10", ack_cyc[0] - st_cyc[0]);
    end
    n_tests++;
    if (ack_data[0] !== 8'hFF || tape_data !== 8'hFF) begin
      n_fail++; $display("FAIL to_data: got %0h/%0h expected ff", ack_data[0], tape_data);
    end
    n_tests++;
    if (timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL to_err: got %b expected 1", timeout_err);
    end
  endtask

  task automatic test_reset_in_wait();
    logic got;
    do_reset();
    mem_lat = 4;
    clear_logs();
    aux_addr = 25'h50; aux_din = 8'h9C; aux_we = 1'b1; aux_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_we === 1'b1) begin got = 1'b1; break; end
    end
    n_tests++;
    if (got !== 1'b1) begin
      n_fail++; $display("FAIL rw_strobe: got %b expected 1", got);
    end
    tick();
    reset = 1'b1; aux_req = 1'b0;
    tick();
    n_tests++;
    if ({mem_we, mem_rd, aux_ack, tape_ack, dl_busy, timeout_err, mem_addr, mem_din, aux_dout} !== '0) begin
      n_fail++; $display("FAIL rw_outputs_zero: got we %b rd %b ack %b addr %0h din %0h expected all 0",
        mem_we, mem_rd, aux_ack, mem_addr, mem_din);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_tests++;
    if (ack_kind.size() != 0 || st_cyc.size() != 1) begin
      n_fail++; $display("FAIL rw_orphan_ignored: got %0d acks %0d strobes expected 0 1",
        ack_kind.size(), st_cyc.size());
    end
    mem_lat = 3;
    aux_addr = 25'h300; aux_we = 1'b0; aux_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (aux_ack === 1'b1) begin aux_req = 1'b0; got = 1'b1; break; end
    end
    n_tests++;
    if (got !== 1'b1 || aux_dout !== 8'h33) begin
      n_fail++; $display("FAIL rw_recover: got ack %b data %0h expected 1 33", got, aux_dout);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = 8'h00;
    mem_arr[10'h100] = 8'h11;
    mem_arr[10'h200] = 8'h22;
    mem_arr[10'h300] = 8'h33;
    reset = 1'b1;
    dl_wr = 1'b0; dl_addr = '0; dl_data = 8'h00;
    tape_rd = 1'b0; tape_addr = '0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_din = 8'h00;
    test_reset();
    test_single_download();
    test_overflow();
    test_dl_in_done();
    test_round_robin();
    test_priority();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pet_sram_arbiter.md
Name: pet_sram_arbiter

Overview:
- Shares the single SDRAM controller port (addr/din/dout/we/rd/ready) among three requesters: the ioctl download writer, the tape playback reader and an auxiliary read/write port for the PRG loader.
- Sits between the mist_io/tape/loader logic and the sram instance in the PET2001 top level, in the 112 MHz clk domain.
- Replaces the ad-hoc `ioctl_download ? ... : ...` address mux with sequenced, acknowledged transfers.

Parameters:
- AW, 25, memory address width
- TIMEOUT, 255, clk cycles to wait for mem_ready before forcing completion (8-bit counter)

Ports:
- clk  in  1  system clock (112 MHz)
- reset  in  1  synchronous, active-high reset
- dl_wr  in  1  one-cycle pulse: download byte valid (ioctl_wr qualified by index)
- dl_addr  in  AW  download byte address
- dl_data  in  8  download byte
- dl_busy  out  1  download holding register occupied
- dl_overflow  out  1  sticky: dl_wr arrived while dl_busy
- tape_rd  in  1  level request: tape read
- tape_addr  in  AW  tape read address
- tape_data  out  8  read data, valid when tape_ack
- tape_ack  out  1  one-cycle completion pulse
- aux_req  in  1  level request from loader
- aux_we  in  1  1 = write, 0 = read; sampled at grant
- aux_addr  in  AW  loader address
- aux_din  in  8  loader write data
- aux_dout  out  8  loader read data, valid when aux_ack
- aux_ack  out  1  one-cycle completion pulse
- mem_addr  out  AW  to sram addr
- mem_din  out  8  to sram din
- mem_dout  in  8  from sram dout
- mem_we  out  1  one-cycle write strobe
- mem_rd  out  1  one-cycle read strobe
- mem_ready  in  1  one-cycle completion pulse from sram
- timeout_err  out  1  sticky: a transfer hit TIMEOUT

Behaviour:
- Reset: all outputs 0; state IDLE; holding register empty; round-robin pointer favours tape; sticky flags cleared.
- Download holding register:
  - dl_wr while empty: capture addr/data, set dl_busy next cycle.
  - dl_wr while busy: byte dropped, dl_overflow set (sticky until reset).
  - dl_busy clears the cycle after the arbiter accepts the entry. A dl_wr in that same cycle is captured, with no overflow.
- Priority:
  - Download buffer is always highest.
  - Tape and aux alternate round-robin; the pointer flips to the other requester after each granted tape/aux transfer.
  - A lone requester is granted back-to-back.
- FSM:
  - IDLE: if any request, latch grant id, addr, data and direction into registers → ISSUE.
  - ISSUE: assert exactly one of mem_we/mem_rd for exactly 1 cycle; clear timer → WAIT.
  - WAIT: on mem_ready, capture mem_dout for reads → DONE. If the timer reaches TIMEOUT: set timeout_err, data = 8'hFF → DONE.
  - DONE: pulse the owner's ack for 1 cycle (download has no ack; its buffer frees here) → IDLE.
- mem_addr/mem_din are held stable from ISSUE through DONE.
- Latency: request seen in IDLE → strobe 1 cycle later → ack 1 cycle after mem_ready. Minimum 3 cycles plus memory latency.
- tape_data/aux_dout hold their last value until the next own ack.
- Requesters must hold req/addr until ack. Deasserting req before grant cancels it; deasserting after grant does not abort the transfer (the ack still pulses).
- mem_ready outside WAIT is ignored.
- Reset mid-transfer returns to IDLE at once and drops any pending download byte; the controller must tolerate the orphan cycle.
- The timer is 8 bits wide; TIMEOUT ≤ 255.

Decomposition:
- Package pet_sram_pkg: state enum (IDLE, ISSUE, WAIT, DONE), grant id enum (G_DL, G_TAPE, G_AUX), AW default.
- One natural sub-module: pet_sram_rr_pick, a 2-way round-robin picker with a download-priority override, combinational plus pointer register.

Test Plan:
- Single download: dl_wr addr 0x10 data 0xA5; mem_ready 4 cycles after mem_we → mem_we 1 cycle with mem_addr=0x10, mem_din=0xA5; dl_busy clears after DONE; dl_overflow=0.
- Overflow: two dl_wr on consecutive cycles while memory stalls → first byte written, second dropped, dl_overflow=1 sticky.
- Round-robin: tape_rd and aux_req (read, 0x200) held continuously, memory returns 0x11/0x22 → grants alternate tape, aux, tape…; tape_ack carries 0x11 and aux_ack carries 0x22, one ack per transfer.
- Priority: aux transfer in WAIT when dl_wr arrives, tape also pending → aux completes first, then download is granted before tape.
- Timeout: tape_rd with mem_ready never asserted, TIMEOUT=8 → tape_ack 10 cycles after mem_rd with tape_data=0xFF; timeout_err=1.
- Reset in WAIT: reset pulse during an aux write → all outputs 0 the next cycle; a late mem_ready is ignored; a new aux request is served normally.
